// File: rtl/triangle_fetch_if.sv
// Triangle load port plus rasterizer stream, bundled between bootloader, store and rasterizer.
// master = triangle store (sinks writes, sources triangles); slave = bootloader/rasterizer side.
interface triangle_fetch_if #(
  parameter int TRI_W = 144
);
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [TRI_W-1:0] wr_data;
  logic [TRI_W-1:0] tri_out;
  logic             tri_valid;
  logic             tri_last;
  logic             tri_ready;
  logic             raster_idle;

  modport master (
    input  wr_en, wr_addr, wr_data, tri_ready, raster_idle,
    output tri_out, tri_valid, tri_last
  );

  modport slave (
    output wr_en, wr_addr, wr_data, tri_ready, raster_idle,
    input  tri_out, tri_valid, tri_last
  );
endinterface

// File: rtl/triangle_fetch.sv
// Triangle RAM + draw sequencer: one triangle per READ/PRESENT pair, first one 2 cycles after start.
// tri_out is held while tri_ready is low; the pass finishes only once the rasterizer reports idle.
module triangle_fetch #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10,
  parameter int TRI_W  = 144,
  parameter int TIME_W = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  triangle_fetch_if.master    bus,
  input  logic                load_mode,
  input  logic                start,
  output logic                done_drawing,
  output logic [TIME_W-1:0]   fill_time,
  output logic [ADDR_W:0]     tri_count,
  output logic                wr_overflow,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, READ, PRESENT, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0]   ONE  = 1;
  localparam logic [TIME_W-1:0] TONE = 1;

  state_t             state_q, state_d;
  logic [TRI_W-1:0]   ram [DEPTH];
  logic [TRI_W-1:0]   tri_out_q;
  logic [ADDR_W:0]    idx_q, pass_n_q, tri_count_q, tri_count_d, wr_cnt;
  logic [TIME_W-1:0]  cnt_q, cnt_inc, fill_time_q;
  logic               load_q, load_rise, wr_overflow_q, wr_overflow_d;
  logic               wr_in_range, start_acc, is_last, handshake;

  assign wr_in_range = bus.wr_addr < 32'(DEPTH);
  assign wr_cnt      = bus.wr_addr[ADDR_W:0] + ONE;
  assign load_rise   = load_mode & ~load_q;
  assign start_acc   = start & ~load_mode & (state_q == IDLE || state_q == DONE);
  assign is_last     = idx_q == pass_n_q - ONE;
  assign handshake   = (state_q == PRESENT) & ~load_mode & bus.tri_ready;
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + TONE;

  // The load_mode edge clears first so a same-cycle write still counts.
  always_comb begin
    tri_count_d   = load_rise ? '0 : tri_count_q;
    wr_overflow_d = load_rise ? 1'b0 : wr_overflow_q;
    if (bus.wr_en) begin
      if (wr_in_range) begin
        if (wr_cnt > tri_count_d) tri_count_d = wr_cnt;
      end else begin
        wr_overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_in_range) ram[bus.wr_addr[ADDR_W-1:0]] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_mode) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) state_d = (tri_count_q != '0) ? READ : DRAIN;
        READ:       state_d = PRESENT;
        PRESENT:    if (bus.tri_ready) state_d = is_last ? DRAIN : READ;
        DRAIN:      if (bus.raster_idle) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tri_out_q     <= '0;
      idx_q         <= '0;
      pass_n_q      <= '0;
      tri_count_q   <= '0;
      cnt_q         <= '0;
      fill_time_q   <= '0;
      load_q        <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      load_q        <= load_mode;
      tri_count_q   <= tri_count_d;
      wr_overflow_q <= wr_overflow_d;
      if (start_acc) begin
        pass_n_q <= tri_count_q;
        idx_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q inside {READ, PRESENT, DRAIN}) begin
        cnt_q <= cnt_inc;
      end
      if (state_q == READ) tri_out_q <= ram[idx_q[ADDR_W-1:0]];
      if (handshake && !is_last) idx_q <= idx_q + ONE;
      if (load_mode) fill_time_q <= '0;
      else if (state_q == DRAIN && bus.raster_idle) fill_time_q <= cnt_inc;
    end
  end

  assign bus.tri_out   = tri_out_q;
  assign bus.tri_valid = (state_q == PRESENT) & ~load_mode;
  assign bus.tri_last  = bus.tri_valid & is_last;
  assign done_drawing  = state_q == DONE;
  assign fill_time     = fill_time_q;
  assign tri_count     = tri_count_q;
  assign wr_overflow   = wr_overflow_q;
  assign busy          = state_q inside {READ, PRESENT, DRAIN};

endmodule

// File: tb/tb_triangle_fetch.sv
// Directed bench for triangle_fetch: draw passes, stalls, empty pass, overflow, load abort, saturation.
module tb_triangle_fetch;
  logic clk = 1'b0;
  logic rst_n;
  logic load_mode, start, done_drawing, wr_overflow, busy;
  logic [23:0] fill_time;
  logic [10:0] tri_count;

  logic start_s, done_s, ovf_s, busy_s;
  logic [3:0]  fill_s;
  logic [10:0] count_s;

  int checks = 0;
  int errors = 0;

  localparam logic [143:0] TA = {9{16'hAAAA}};
  localparam logic [143:0] TB = {9{16'hBBBB}};
  localparam logic [143:0] TC = {9{16'hCCCC}};
  localparam logic [143:0] TD = {9{16'hDDDD}};
  localparam logic [143:0] TE = {9{16'hEEEE}};

  triangle_fetch_if #(.TRI_W(144)) bus ();
  triangle_fetch_if #(.TRI_W(144)) bus_s ();

  triangle_fetch dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .load_mode(load_mode), .start(start),
    .done_drawing(done_drawing), .fill_time(fill_time), .tri_count(tri_count),
    .wr_overflow(wr_overflow), .busy(busy)
  );

  triangle_fetch #(.TIME_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(bus_s), .load_mode(1'b0), .start(start_s),
    .done_drawing(done_s), .fill_time(fill_s), .tri_count(count_s),
    .wr_overflow(ovf_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [143:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_mode = 1'b0; start = 1'b0; start_s = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.tri_ready = 1'b0; bus.raster_idle = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.wr_addr = '0; bus_s.wr_data = '0;
    bus_s.tri_ready = 1'b0; bus_s.raster_idle = 1'b0;
    tick(); tick();
    chk("rst_tri_out", bus.tri_out, '0);
    chk("rst_valid", bus.tri_valid, 0);
    chk("rst_last", bus.tri_last, 0);
    chk("rst_done", done_drawing, 0);
    chk("rst_fill", fill_time, 0);
    chk("rst_count", tri_count, 0);
    chk("rst_ovf", wr_overflow, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // Ideal pass of three triangles
    wr(0, TA); wr(1, TB); wr(2, TC);
    chk("t1_count", tri_count, 3);
    bus.tri_ready = 1'b1; bus.raster_idle = 1'b1;
    start = 1'b1; tick(); start = 1'b0;                     // cycle 1
    chk("t1_c1_busy", busy, 1);
    chk("t1_c1_valid", bus.tri_valid, 0);
    tick();                                                  // cycle 2
    chk("t1_c2_valid", bus.tri_valid, 1);
    chk("t1_c2_out", bus.tri_out, TA);
    chk("t1_c2_last", bus.tri_last, 0);
    tick();
    chk("t1_c3_valid", bus.tri_valid, 0);
    tick();                                                  // cycle 4
    chk("t1_c4_out", bus.tri_out, TB);
    chk("t1_c4_last", bus.tri_last, 0);
    tick(); tick();                                          // cycle 6
    chk("t1_c6_out", bus.tri_out, TC);
    chk("t1_c6_last", bus.tri_last, 1);
    tick();                                                  // cycle 7
    chk("t1_c7_done", done_drawing, 0);
    chk("t1_c7_busy", busy, 1);
    tick();                                                  // cycle 8
    chk("t1_c8_done", done_drawing, 1);
    chk("t1_fill", fill_time, 7);
    chk("t1_busy_done", busy, 0);

    // Restart from DONE with a 5-cycle stall on B
    start = 1'b1; tick(); start = 1'b0;                     // cycle 1
    chk("t2_done_drop", done_drawing, 0);
    tick();
    chk("t2_c2_out", bus.tri_out, TA);
    tick(); tick();                                          // cycle 4
    bus.tri_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", bus.tri_valid, 1);
      chk("t2_stall_out", bus.tri_out, TB);
      tick();
    end
    chk("t2_c9_out", bus.tri_out, TB);
    bus.tri_ready = 1'b1;
    tick(); tick();                                          // cycle 11
    chk("t2_c11_out", bus.tri_out, TC);
    chk("t2_c11_last", bus.tri_last, 1);
    tick(); tick();                                          // cycle 13
    chk("t2_done", done_drawing, 1);
    chk("t2_fill", fill_time, 12);

    // Empty pass, then a one-triangle pass with a slow drain
    load_mode = 1'b1; tick();
    chk("t3_load_count", tri_count, 0);
    chk("t3_load_done", done_drawing, 0);
    chk("t3_load_fill", fill_time, 0);
    load_mode = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_empty_busy", busy, 1);
    chk("t3_empty_valid", bus.tri_valid, 0);
    tick();
    chk("t3_empty_done", done_drawing, 1);
    chk("t3_empty_fill", fill_time, 1);
    wr(0, TD);
    bus.raster_idle = 1'b0;
    start = 1'b1; tick(); start = 1'b0;                     // cycle 1
    tick();                                                  // cycle 2
    chk("t3_one_out", bus.tri_out, TD);
    chk("t3_one_last", bus.tri_last, 1);
    tick(); tick(); tick(); tick();                          // cycle 6
    chk("t3_drain_done", done_drawing, 0);
    chk("t3_drain_busy", busy, 1);
    tick();                                                  // cycle 7
    bus.raster_idle = 1'b1;
    tick();
    chk("t3_slow_done", done_drawing, 1);
    chk("t3_slow_fill", fill_time, 7);

    // Out-of-range write is dropped and flagged
    wr(1024, TE);
    chk("t4_ovf", wr_overflow, 1);
    chk("t4_count", tri_count, 1);
    tick();
    chk("t4_ovf_sticky", wr_overflow, 1);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t4_ram_kept", bus.tri_out, TD);
    tick(); tick();
    chk("t4_fill", fill_time, 3);
    load_mode = 1'b1; tick();
    chk("t4_load_ovf", wr_overflow, 0);
    chk("t4_load_count", tri_count, 0);
    wr(2, TC);
    wr(0, TA);
    chk("t4_count_max", tri_count, 3);
    wr(1, TB);
    load_mode = 1'b0; tick();

    // load_mode aborts a pass; next pass starts at index 0
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t5_c2_out", bus.tri_out, TA);
    tick(); tick();
    chk("t5_c4_out", bus.tri_out, TB);
    load_mode = 1'b1; tick();
    chk("t5_abort_valid", bus.tri_valid, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done_drawing, 0);
    chk("t5_abort_fill", fill_time, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_start_ignored", busy, 0);
    wr(0, TA); wr(1, TB); wr(2, TC);
    load_mode = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t5_restart_out", bus.tri_out, TA);
    chk("t5_restart_last", bus.tri_last, 0);

    // Synchronous reset mid-pass
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_valid", bus.tri_valid, 0);
    chk("t5_rst_out", bus.tri_out, '0);
    chk("t5_rst_count", tri_count, 0);
    tick();

    // Cycle counter saturation on the 4-bit build
    bus_s.wr_en = 1'b1; bus_s.wr_addr = 0; bus_s.wr_data = TA;
    tick();
    bus_s.wr_en = 1'b0;
    chk("t6_count", count_s, 1);
    bus_s.raster_idle = 1'b1;
    start_s = 1'b1; tick(); start_s = 1'b0;
    tick();
    repeat (20) tick();
    chk("t6_stall_valid", bus_s.tri_valid, 1);
    bus_s.tri_ready = 1'b1;
    tick(); tick();
    chk("t6_done", done_s, 1);
    chk("t6_fill_sat", fill_s, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/triangle_fetch.md
Name: triangle_fetch

Overview:
- Triangle store and sequencer between the UART bootloader and the rasterizer.
- Accepts bootloaded 144-bit triangles into an internal RAM and tracks how many were loaded.
- On start, streams them to the rasterizer over a valid/ready handshake.
- Produces the done_drawing flag and 24-bit fill_time cycle count consumed by the frame-buffer transmitter.

Parameters:
- DEPTH, 1024, triangle RAM entries.
- ADDR_W, 10, log2(DEPTH).
- TRI_W, 144, bits per triangle.
- TIME_W, 24, width of fill_time.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset: one clock; synchronous, active-low. Board reset, not the bootloader's system reset, so loaded data survives bootload.
- load_mode  in  1  bootload_en; high while bootloading.
- wr_en  in  1  triangle write strobe (bootloader triangle_valid).
- wr_addr  in  32  triangle index.
- wr_data  in  TRI_W  triangle payload.
- start  in  1  begin a draw pass.
- tri_ready  in  1  rasterizer accepts tri_out.
- raster_idle  in  1  rasterizer has no triangle in flight.
- tri_out  out  TRI_W  current triangle.
- tri_valid  out  1  tri_out valid.
- tri_last  out  1  tri_out is final triangle of pass.
- done_drawing  out  1  pass complete.
- fill_time  out  TIME_W  cycles of last pass.
- tri_count  out  ADDR_W+1  triangles loaded.
- wr_overflow  out  1  sticky: write addressed >= DEPTH.
- busy  out  1  state not IDLE/DONE.

Behaviour:
- Reset (rst_n low at posedge): state IDLE. All outputs 0: tri_out, tri_valid, tri_last, done_drawing, fill_time, tri_count, wr_overflow, busy. RAM contents not reset.
- Write port, any state:
  - wr_en & wr_addr<DEPTH: RAM[wr_addr]<=wr_data; tri_count<=max(tri_count, wr_addr+1).
  - wr_en & wr_addr>=DEPTH: write dropped, wr_overflow<=1.
- load_mode rising edge (registered compare): tri_count<=0, wr_overflow<=0. Same-cycle write is applied after the clear (count becomes wr_addr+1).
- load_mode high: state forced to IDLE next cycle; tri_valid=0, done_drawing<=0, fill_time<=0; start ignored.
- Pass count: pass_n<=tri_count snapshotted when start is accepted. Later writes do not change the current pass.
- FSM states:
  - IDLE: start & ~load_mode -> clear cycle counter, idx<=0. Go to READ if pass_n!=0, else DRAIN.
  - READ: RAM read of idx (1-cycle synchronous read), registered into tri_out -> PRESENT.
  - PRESENT: tri_valid=1; tri_last=(idx==pass_n-1). tri_out stable while ~tri_ready.
    - On tri_ready & last -> DRAIN.
    - On tri_ready & not last -> idx+1, READ.
  - DRAIN: wait raster_idle -> DONE.
  - DONE: done_drawing=1, fill_time held. start -> restart as from IDLE; done_drawing drops next cycle.
- Throughput: one triangle per 2 cycles maximum.
- Cycle counter: cleared in the start cycle; +1 every cycle in READ/PRESENT/DRAIN; saturates at 2^TIME_W-1. fill_time<=counter on entry to DONE.
- Ideal case (ready and raster_idle always high): fill_time=2N+1.
- busy=1 in READ/PRESENT/DRAIN.
- Mid-pass synchronous reset: immediate IDLE, everything cleared as in reset.

Test Plan:
- Write 3 triangles (addr 0,1,2, data 0xA..,0xB..,0xC..), start, tri_ready=raster_idle=1 -> tri_out A,B,C on cycles 2,4,6; tri_last only with C; done_drawing high at cycle 8; fill_time=7; tri_count=3.
- Same 3 triangles, tri_ready low 5 cycles while B presented -> tri_out holds B stable, no skip/duplicate; fill_time=12.
- tri_count=0, start -> no tri_valid; DONE after 1 DRAIN cycle; fill_time=1. Then hold raster_idle low 4 cycles on a 1-triangle pass -> fill_time=7.
- Write addr 1024 -> RAM and tri_count unchanged, wr_overflow=1. Raise load_mode -> wr_overflow=0, tri_count=0.
- Raise load_mode during PRESENT of triangle 1 of 3 -> next cycle IDLE, tri_valid=0, done_drawing=0, fill_time=0. Drop load_mode, start -> pass restarts at index 0.
- Force counter near saturation (TIME_W=4 build, 20-cycle stall) -> fill_time=15.
